// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// maze_pkg : tile codes, map geometry and helpers shared by the maze path.
// Revision : 1.0
// ============================================================================
package maze_pkg;

  localparam int MAP_W   = 21;
  localparam int MAP_H   = 21;
  localparam int TILE_W  = 3;
  localparam int COORD_W = 5;
  localparam int IDX_W   = 9;
  localparam int COUNT_W = 9;

  localparam logic [TILE_W-1:0] TILE_EMPTY     = 3'b000;
  localparam logic [TILE_W-1:0] TILE_BIG_ORB   = 3'b001;
  localparam logic [TILE_W-1:0] TILE_SMALL_ORB = 3'b010;
  localparam logic [TILE_W-1:0] TILE_WALL      = 3'b011;
  localparam logic [TILE_W-1:0] TILE_PLAYER    = 3'b100;

  localparam logic [COORD_W-1:0] MAX_X          = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] MAX_Y          = COORD_W'(MAP_H - 1);
  localparam logic [COORD_W-1:0] PLAYER_START_X = 5'd10;
  localparam logic [COORD_W-1:0] PLAYER_START_Y = 5'd8;
  localparam logic [COORD_W-1:0] BIG_ORB_NEAR   = 5'd1;
  localparam logic [COORD_W-1:0] BIG_ORB_FAR    = 5'd19;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } store_state_t;

  // Codes 101-111 count as wall, so only the two orb codes qualify.
  function automatic logic is_orb(input logic [TILE_W-1:0] tile);
    return (tile == TILE_BIG_ORB) || (tile == TILE_SMALL_ORB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/map_tile_store_if.sv
`default_nettype none
// ============================================================================
// map_tile_store_if : display lookup, game query/write and status bundle.
// Revision : 1.0
// ============================================================================
interface map_tile_store_if;
  import maze_pkg::*;

  logic [COORD_W-1:0] map_x;
  logic [COORD_W-1:0] map_y;
  logic [TILE_W-1:0]  sprite_type;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic [TILE_W-1:0]  rd_tile;
  logic               wr_req;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [TILE_W-1:0]  wr_tile;
  logic               wr_ack;
  logic               wr_err;
  logic               ready;
  logic [COUNT_W-1:0] orb_count;
  logic               orbs_cleared;

  modport master (
    output map_x, map_y, rd_x, rd_y, wr_req, wr_x, wr_y, wr_tile,
    input  sprite_type, rd_tile, wr_ack, wr_err, ready, orb_count, orbs_cleared
  );

  modport slave (
    input  map_x, map_y, rd_x, rd_y, wr_req, wr_x, wr_y, wr_tile,
    output sprite_type, rd_tile, wr_ack, wr_err, ready, orb_count, orbs_cleared
  );
endinterface
`default_nettype wire

// File: rtl/map_layout_rom.sv
`default_nettype none
// ============================================================================
// map_layout_rom : combinational default maze layout, (x,y) -> sprite code.
// Revision : 1.0
// ============================================================================
module map_layout_rom
  import maze_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [TILE_W-1:0]  tile
);

  // Rule order matters: border beats player beats big orbs beats pillars.
  always_comb begin
    tile = TILE_SMALL_ORB;
    if (x == '0 || x == MAX_X || y == '0 || y == MAX_Y) begin
      tile = TILE_WALL;
    end else if (x == PLAYER_START_X && y == PLAYER_START_Y) begin
      tile = TILE_PLAYER;
    end else if ((x == BIG_ORB_NEAR || x == BIG_ORB_FAR) &&
                 (y == BIG_ORB_NEAR || y == BIG_ORB_FAR)) begin
      tile = TILE_BIG_ORB;
    end else if (!x[0] && !y[0]) begin
      tile = TILE_WALL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/map_tile_store.sv
`default_nettype none
// ============================================================================
// map_tile_store : maze tile memory with self-load, display/query reads,
//                  req/ack write port and remaining-orb counter.
// Revision : 1.0
// ============================================================================
module map_tile_store
  import maze_pkg::*;
#(
  parameter int MAP_W  = 21,
  parameter int MAP_H  = 21,
  parameter int TILE_W = 3
) (
  input  logic            clock_50,
  input  logic            reset,
  map_tile_store_if.slave bus
);

  localparam int                 MAP_SIZE   = MAP_W * MAP_H;
  localparam logic [COORD_W-1:0] LIM_X      = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] LIM_Y      = COORD_W'(MAP_H - 1);
  localparam logic [IDX_W-1:0]   ROW_STRIDE = IDX_W'(MAP_W);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(MAP_SIZE - 1);

  function automatic logic in_map(input logic [COORD_W-1:0] x,
                                  input logic [COORD_W-1:0] y);
    return (x <= LIM_X) && (y <= LIM_Y);
  endfunction

  function automatic logic [IDX_W-1:0] lin_idx(input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y);
    return IDX_W'(y) * ROW_STRIDE + IDX_W'(x);
  endfunction

  store_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] init_x_q, init_x_d;
  logic [COORD_W-1:0] init_y_q, init_y_d;
  logic [COUNT_W-1:0] orb_count_q, orb_count_d;
  logic               ready_q, ready_d;
  logic               wr_ack_q, wr_ack_d;
  logic               wr_err_q, wr_err_d;
  logic [TILE_W-1:0]  rd_tile_q, rd_tile_d;
  logic [COORD_W-1:0] cap_x_q, cap_x_d;
  logic [COORD_W-1:0] cap_y_q, cap_y_d;
  logic [TILE_W-1:0]  cap_tile_q, cap_tile_d;

  logic [TILE_W-1:0]  mem_q [MAP_SIZE];
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [TILE_W-1:0]  mem_wdata;
  logic [TILE_W-1:0]  rom_tile;
  logic [TILE_W-1:0]  old_tile;
  logic [IDX_W-1:0]   wr_idx;

  map_layout_rom u_layout_rom (
    .x    (init_x_q),
    .y    (init_y_q),
    .tile (rom_tile)
  );

  assign wr_idx   = lin_idx(cap_x_q, cap_y_q);
  assign old_tile = mem_q[wr_idx];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_x_d    = init_x_q;
    init_y_d    = init_y_q;
    orb_count_d = orb_count_q;
    ready_d     = ready_q;
    wr_ack_d    = 1'b0;
    wr_err_d    = 1'b0;
    cap_x_d     = cap_x_q;
    cap_y_d     = cap_y_q;
    cap_tile_d  = cap_tile_q;
    mem_we      = 1'b0;
    mem_waddr   = idx_q;
    mem_wdata   = rom_tile;
    rd_tile_d   = (ready_q && in_map(bus.rd_x, bus.rd_y)) ?
                  mem_q[lin_idx(bus.rd_x, bus.rd_y)] : TILE_EMPTY;

    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        if (is_orb(rom_tile)) begin
          orb_count_d = orb_count_q + COUNT_W'(1);
        end
        idx_d = idx_q + 1'b1;
        if (init_x_q == LIM_X) begin
          init_x_d = '0;
          init_y_d = init_y_q + 1'b1;
        end else begin
          init_x_d = init_x_q + 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        // Ack is registered here so it is visible throughout the WRITE cycle.
        if (bus.wr_req) begin
          cap_x_d    = bus.wr_x;
          cap_y_d    = bus.wr_y;
          cap_tile_d = bus.wr_tile;
          wr_ack_d   = 1'b1;
          wr_err_d   = !in_map(bus.wr_x, bus.wr_y);
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        if (!wr_err_q) begin
          mem_we      = 1'b1;
          mem_waddr   = wr_idx;
          mem_wdata   = cap_tile_q;
          orb_count_d = orb_count_q + COUNT_W'(is_orb(cap_tile_q))
                                    - COUNT_W'(is_orb(old_tile));
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      init_x_q    <= '0;
      init_y_q    <= '0;
      orb_count_q <= '0;
      ready_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_tile_q   <= TILE_EMPTY;
      cap_x_q     <= '0;
      cap_y_q     <= '0;
      cap_tile_q  <= TILE_EMPTY;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_x_q    <= init_x_d;
      init_y_q    <= init_y_d;
      orb_count_q <= orb_count_d;
      ready_q     <= ready_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      rd_tile_q   <= rd_tile_d;
      cap_x_q     <= cap_x_d;
      cap_y_q     <= cap_y_d;
      cap_tile_q  <= cap_tile_d;
    end
  end

  // A reset landing on the WRITE edge must drop the pending write.
  always_ff @(posedge clock_50) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.sprite_type  = (ready_q && in_map(bus.map_x, bus.map_y)) ?
                            mem_q[lin_idx(bus.map_x, bus.map_y)] : TILE_EMPTY;
  assign bus.rd_tile      = rd_tile_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.wr_err       = wr_err_q;
  assign bus.ready        = ready_q;
  assign bus.orb_count    = orb_count_q;
  assign bus.orbs_cleared = ready_q && (orb_count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_map_tile_store.sv
`default_nettype none
// ============================================================================
// tb_map_tile_store : directed self-checking bench for map_tile_store.
// Revision : 1.0
// ============================================================================
module tb_map_tile_store;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  map_tile_store_if bus ();

  map_tile_store dut (
    .clock_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_write(input int x, input int y, input int t,
                          output int lat, output logic err);
    bus.wr_x    = 5'(x);
    bus.wr_y    = 5'(y);
    bus.wr_tile = 3'(t);
    bus.wr_req  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.wr_ack !== 1'b1 && lat < 8);
    err = bus.wr_err;
    bus.wr_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int   cycles;
    logic ack_seen;
    bus.wr_req = 1'b1; bus.wr_x = 5'd3; bus.wr_y = 5'd3; bus.wr_tile = 3'd0;
    bus.map_x = 5'd1; bus.map_y = 5'd1; bus.rd_x = 5'd1; bus.rd_y = 5'd1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.ready); end
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL rst_wr_ack got %b want 0", bus.wr_ack); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL rst_wr_err got %b want 0", bus.wr_err); end
    checks++; if (bus.rd_tile !== 3'd0) begin errors++; $display("FAIL rst_rd_tile got %0d want 0", bus.rd_tile); end
    checks++; if (bus.orb_count !== 9'd0) begin errors++; $display("FAIL rst_orb_count got %0d want 0", bus.orb_count); end
    checks++; if (bus.sprite_type !== 3'd0) begin errors++; $display("FAIL rst_sprite got %0d want 0", bus.sprite_type); end
    reset = 1'b0;
    cycles = 0; ack_seen = 1'b0;
    while (bus.ready !== 1'b1 && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.wr_ack === 1'b1) ack_seen = 1'b1;
      if (cycles == 100) begin
        checks++; if (bus.sprite_type !== 3'd0 || bus.rd_tile !== 3'd0) begin
          errors++; $display("FAIL init_blank sprite %0d rd %0d want 0 0", bus.sprite_type, bus.rd_tile);
        end
      end
      if (cycles == 300) bus.wr_req = 1'b0;
    end
    checks++; if (cycles != 441) begin errors++; $display("FAIL init_latency got %0d want 441", cycles); end
    checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL init_ack got %b want 0", ack_seen); end
    checks++; if (bus.orb_count !== 9'd280) begin errors++; $display("FAIL init_orbs got %0d want 280", bus.orb_count); end
    checks++; if (bus.orbs_cleared !== 1'b0) begin errors++; $display("FAIL init_cleared got %b want 0", bus.orbs_cleared); end
  endtask

  task automatic test_display();
    int xs [10] = '{0, 1, 10, 2, 3, 25, 20, 19, 5, 1};
    int ys [10] = '{0, 1, 8, 2, 2, 3, 20, 19, 31, 19};
    int ex [10] = '{3, 1, 4, 3, 2, 0, 3, 1, 0, 1};
    for (int i = 0; i < 10; i++) begin
      bus.map_x = 5'(xs[i]); bus.map_y = 5'(ys[i]);
      bus.rd_x  = 5'(xs[i]); bus.rd_y  = 5'(ys[i]);
      #1;
      checks++; if (bus.sprite_type !== 3'(ex[i])) begin
        errors++; $display("FAIL disp(%0d,%0d) got %0d want %0d", xs[i], ys[i], bus.sprite_type, ex[i]);
      end
      @(posedge clk); #1;
      checks++; if (bus.rd_tile !== 3'(ex[i])) begin
        errors++; $display("FAIL query(%0d,%0d) got %0d want %0d", xs[i], ys[i], bus.rd_tile, ex[i]);
      end
    end
  endtask

  task automatic test_write();
    int   lat;
    logic err;
    bus.map_x = 5'd3; bus.map_y = 5'd2; bus.rd_x = 5'd3; bus.rd_y = 5'd2;
    do_write(3, 2, 0, lat, err);
    checks++; if (lat != 1) begin errors++; $display("FAIL wr_latency got %0d want 1", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", err); end
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse got %b want 0", bus.wr_ack); end
    checks++; if (bus.orb_count !== 9'd279) begin errors++; $display("FAIL wr_orbs got %0d want 279", bus.orb_count); end
    checks++; if (bus.rd_tile !== 3'd2) begin errors++; $display("FAIL query_old got %0d want 2", bus.rd_tile); end
    checks++; if (bus.sprite_type !== 3'd0) begin errors++; $display("FAIL disp_new got %0d want 0", bus.sprite_type); end
    @(posedge clk); #1;
    checks++; if (bus.rd_tile !== 3'd0) begin errors++; $display("FAIL query_new got %0d want 0", bus.rd_tile); end
  endtask

  task automatic test_write_err();
    int   lat;
    logic err;
    bus.map_x = 5'd0; bus.map_y = 5'd6;
    do_write(21, 5, 2, lat, err);
    checks++; if (lat != 1 || err !== 1'b1) begin errors++; $display("FAIL oor_ack lat %0d err %b want 1 1", lat, err); end
    checks++; if (bus.orb_count !== 9'd279) begin errors++; $display("FAIL oor_orbs got %0d want 279", bus.orb_count); end
    checks++; if (bus.sprite_type !== 3'd3) begin errors++; $display("FAIL oor_alias got %0d want 3", bus.sprite_type); end
    bus.map_x = 5'd0; bus.map_y = 5'd0;
    do_write(0, 0, 1, lat, err);
    checks++; if (bus.orb_count !== 9'd280 || err !== 1'b0) begin errors++; $display("FAIL wall_to_orb orbs %0d err %b want 280 0", bus.orb_count, err); end
    checks++; if (bus.sprite_type !== 3'd1) begin errors++; $display("FAIL wall_to_orb_disp got %0d want 1", bus.sprite_type); end
    do_write(3, 3, 1, lat, err);
    checks++; if (bus.orb_count !== 9'd280) begin errors++; $display("FAIL orb_to_orb got %0d want 280", bus.orb_count); end
    do_write(3, 3, 5, lat, err);
    checks++; if (bus.orb_count !== 9'd279) begin errors++; $display("FAIL orb_to_101 got %0d want 279", bus.orb_count); end
  endtask

  task automatic test_clear();
    int   lat;
    logic err;
    int   bad = 0;
    for (int y = 0; y < 21; y++) begin
      for (int x = 0; x < 21; x++) begin
        if (!(x == 1 && y == 1)) begin
          do_write(x, y, 0, lat, err);
          if (lat != 1 || err !== 1'b0) bad++;
        end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_acks got %0d bad want 0", bad); end
    checks++; if (bus.orb_count !== 9'd1 || bus.orbs_cleared !== 1'b0) begin
      errors++; $display("FAIL clear_last orbs %0d cleared %b want 1 0", bus.orb_count, bus.orbs_cleared);
    end
    do_write(1, 1, 0, lat, err);
    checks++; if (bus.orb_count !== 9'd0 || bus.orbs_cleared !== 1'b1) begin
      errors++; $display("FAIL cleared orbs %0d cleared %b want 0 1", bus.orb_count, bus.orbs_cleared);
    end
    do_write(1, 1, 1, lat, err);
    checks++; if (bus.orb_count !== 9'd1 || bus.orbs_cleared !== 1'b0) begin
      errors++; $display("FAIL reorb orbs %0d cleared %b want 1 0", bus.orb_count, bus.orbs_cleared);
    end
  endtask

  task automatic test_reset_mid_write();
    int cycles;
    bus.map_x = 5'd3; bus.map_y = 5'd2; bus.rd_x = 5'd3; bus.rd_y = 5'd2;
    bus.wr_x = 5'd5; bus.wr_y = 5'd5; bus.wr_tile = 3'd1; bus.wr_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL mw_capture got %b want 1", bus.wr_ack); end
    reset = 1'b1; bus.wr_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.wr_ack !== 1'b0 || bus.wr_err !== 1'b0) begin errors++; $display("FAIL mw_ack ack %b err %b want 0 0", bus.wr_ack, bus.wr_err); end
    checks++; if (bus.ready !== 1'b0 || bus.orb_count !== 9'd0) begin errors++; $display("FAIL mw_state ready %b orbs %0d want 0 0", bus.ready, bus.orb_count); end
    checks++; if (bus.rd_tile !== 3'd0 || bus.sprite_type !== 3'd0) begin errors++; $display("FAIL mw_reads rd %0d sprite %0d want 0 0", bus.rd_tile, bus.sprite_type); end
    reset = 1'b0;
    cycles = 0;
    while (bus.ready !== 1'b1 && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
    end
    checks++; if (cycles != 441) begin errors++; $display("FAIL mw_latency got %0d want 441", cycles); end
    checks++; if (bus.orb_count !== 9'd280) begin errors++; $display("FAIL mw_orbs got %0d want 280", bus.orb_count); end
    checks++; if (bus.sprite_type !== 3'd2) begin errors++; $display("FAIL mw_relayout got %0d want 2", bus.sprite_type); end
  endtask

  task automatic test_reset_mid_init();
    int   cycles;
    logic ack_seen;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
    end
    checks++; if (bus.orb_count !== 9'd126 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL mi_partial orbs %0d ready %b want 126 0", bus.orb_count, bus.ready);
    end
    reset = 1'b1;
    bus.wr_x = 5'd4; bus.wr_y = 5'd3; bus.wr_tile = 3'd0; bus.wr_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.orb_count !== 9'd0 || bus.wr_ack !== 1'b0 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL mi_reset orbs %0d ack %b ready %b want 0 0 0", bus.orb_count, bus.wr_ack, bus.ready);
    end
    reset = 1'b0;
    cycles = 0; ack_seen = 1'b0;
    while (bus.ready !== 1'b1 && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.wr_ack === 1'b1) ack_seen = 1'b1;
      if (cycles == 100) bus.wr_req = 1'b0;
    end
    checks++; if (cycles != 441 || ack_seen !== 1'b0) begin
      errors++; $display("FAIL mi_restart cycles %0d ack %b want 441 0", cycles, ack_seen);
    end
    checks++; if (bus.orb_count !== 9'd280) begin errors++; $display("FAIL mi_orbs got %0d want 280", bus.orb_count); end
  endtask

  initial begin
    bus.map_x = '0; bus.map_y = '0; bus.rd_x = '0; bus.rd_y = '0;
    bus.wr_req = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_tile = '0;
    test_reset();
    test_display();
    test_write();
    test_write_err();
    test_clear();
    test_reset_mid_write();
    test_reset_mid_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
